// File: rtl/dm_initiator.sv
// MEM-stage load/store initiator: one word-aligned req/ack memory access per op, with load extension.
// Optional store tracing is compiled in with MEM_TRACE_EN.
module dm_initiator (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] OP_LW = 4'h0, OP_LH = 4'h1, OP_LHU = 4'h2, OP_LB = 4'h3,
                         OP_LBU = 4'h4, OP_SW = 4'h8, OP_SH = 4'h9, OP_SB = 4'hA;

  state_t      r_state, w_next;
  logic [3:0]  r_op;
  logic [1:0]  r_lane;
  logic        r_mem_req, r_mem_we, r_rdata_valid;
  logic [31:0] r_mem_addr, r_mem_wdata, r_rdata;
  logic [3:0]  r_mem_be;

  logic        w_is_load, w_is_store, w_aligned, w_accept;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ext;
  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Decode of the op currently presented by the pipeline.
  always_comb begin
    w_is_load  = (op_type <= OP_LBU);
    w_is_store = (op_type == OP_SW) || (op_type == OP_SH) || (op_type == OP_SB);
    w_aligned  = 1'b1;
    w_be       = 4'b1111;
    w_wdata    = wdata;
    case (op_type)
      OP_LW, OP_SW:         w_aligned = (addr[1:0] == 2'b00);
      OP_LH, OP_LHU, OP_SH: w_aligned = ~addr[0];
      default:              w_aligned = 1'b1;
    endcase
    case (op_type)
      OP_SH: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wdata[15:0]}};
      end
      OP_SB: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = wdata;
      end
    endcase
  end

  assign w_accept = (r_state == IDLE) && op_valid && (w_is_load || w_is_store) && w_aligned;
  assign misalign = (r_state == IDLE) && op_valid && (w_is_load || w_is_store) && !w_aligned;
  assign stall    = w_accept || (r_state == REQ);

  // Lane selection uses the latched address bits, not the live pipeline address.
  always_comb begin
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
    case (r_op)
      OP_LH:   w_ext = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_ext = {16'h0000, w_half};
      OP_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_ext = {24'h000000, w_byte};
      default: w_ext = mem_rdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = REQ;
      REQ:     if (mem_ack)  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_op          <= 4'h0;
      r_lane        <= 2'b00;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 32'h0;
      r_mem_be      <= 4'h0;
      r_mem_wdata   <= 32'h0;
      r_rdata       <= 32'h0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_rdata_valid <= 1'b0;
      if (w_accept) begin
        r_op        <= op_type;
        r_lane      <= addr[1:0];
        r_mem_req   <= 1'b1;
        r_mem_we    <= w_is_store;
        r_mem_addr  <= {addr[31:2], 2'b00};
        r_mem_be    <= w_be;
        r_mem_wdata <= w_wdata;
      end
      if (r_state == REQ && mem_ack) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
        if (!r_op[3]) begin
          r_rdata       <= w_ext;
          r_rdata_valid <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_TRACE_EN
  logic [31:0] r_pc;
  logic [31:0] w_merged;
  assign w_merged = r_mem_wdata & {{8{r_mem_be[3]}}, {8{r_mem_be[2]}}, {8{r_mem_be[1]}}, {8{r_mem_be[0]}}};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= 32'h0;
    end else begin
      if (w_accept) r_pc <= pc;
      if (r_state == REQ && mem_ack && r_mem_we)
        $display("%d@%h: *%h <= %h", $time, r_pc, r_mem_addr, w_merged);
    end
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^pc;
`endif

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_be      = r_mem_be;
  assign mem_wdata   = r_mem_wdata;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign dbg_state   = r_state;
endmodule
